// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard scoreboard: forward-select encoding,
// the shadow-pipeline stage record and a tag-match helper.
package hazard_pkg;

    localparam int unsigned FORWARD_SEL_WIDTH = 2;
    localparam int unsigned SHADOW_RD_WIDTH   = 5;
    localparam int unsigned SHADOW_DEPTH      = 3;  // EXE, MEM, WB

    localparam int unsigned STG_EXE = 0;
    localparam int unsigned STG_MEM = 1;
    localparam int unsigned STG_WB  = 2;

    typedef enum logic [FORWARD_SEL_WIDTH-1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                       valid;
        logic [SHADOW_RD_WIDTH-1:0] rd;
        logic                       we;
        logic                       is_load;
    } shadow_t;

    // True when a shadow stage will write the given nonzero source register.
    function automatic logic shadow_hit(input shadow_t s, input logic [SHADOW_RD_WIDTH-1:0] src);
        return s.valid && s.we && (s.rd != '0) && (s.rd == src);
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: a countdown of cycles until a pending load result
// can be consumed. A new set always overrides the decrement.
module hazard_sb_entry #(
    parameter int unsigned CNT_WIDTH = 2,
    parameter int unsigned LOAD_LAT  = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic set_i,
    input  logic dec_i,
    output logic busy_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Next count: set to the load latency, else count down toward zero.
    always_comb begin
        cnt_d = cnt_q;
        if (set_i) begin
            cnt_d = CNT_WIDTH'(LOAD_LAT);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding controller for the 5-stage integer pipeline.
// Per-register load scoreboard, EXE/MEM/WB shadow tags, registered forward
// selects and stall/flush generation.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush perf counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned LOAD_LAT       = 1,
    parameter int unsigned CNT_WIDTH      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         id_valid,
    input  logic [REG_ADDR_WIDTH-1:0]    id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0]    id_rs2_addr,
    input  logic                         id_rs1_used,
    input  logic                         id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0]    id_rd_addr,
    input  logic                         id_rd_we,
    input  logic                         id_is_load,
    input  logic                         exe_br_taken,
    input  logic                         ext_stall,
    output logic                         stall_if,
    output logic                         stall_id,
    output logic                         flush_if,
    output logic                         flush_id,
    output logic [FORWARD_SEL_WIDTH-1:0] forward_a_sel,
    output logic [FORWARD_SEL_WIDTH-1:0] forward_b_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]                  perf_stall_cnt,
    output logic [15:0]                  perf_flush_cnt
`endif
);

    logic [NUM_REGS-1:0] busy;
    logic                advance;
    logic                rs1_busy, rs2_busy;
    logic                raw_hazard;
    logic                issue;
    logic                set_load;

    shadow_t             pipe_q [SHADOW_DEPTH];
    shadow_t             exe_d;
    fwd_sel_t            fwd_a_q, fwd_a_d;
    fwd_sel_t            fwd_b_q, fwd_b_d;

    assign advance    = !ext_stall;
    assign rs1_busy   = id_rs1_used && (id_rs1_addr != '0) && busy[id_rs1_addr];
    assign rs2_busy   = id_rs2_used && (id_rs2_addr != '0) && busy[id_rs2_addr];
    assign raw_hazard = id_valid && (rs1_busy || rs2_busy);
    assign issue      = id_valid && !ext_stall && !exe_br_taken && !raw_hazard;
    assign set_load   = issue && id_is_load && id_rd_we && (id_rd_addr != '0);

    // x0 is hard-wired and never tracked.
    assign busy[0] = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_sb
        hazard_sb_entry #(
            .CNT_WIDTH (CNT_WIDTH),
            .LOAD_LAT  (LOAD_LAT)
        ) u_entry (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .set_i  (set_load && (id_rd_addr == REG_ADDR_WIDTH'(g))),
            .dec_i  (advance),
            .busy_o (busy[g])
        );
    end

    // Stall/flush priority: external freeze, then branch redirect, then RAW stall.
    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_if = 1'b0;
        flush_id = 1'b0;
        if (ext_stall) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (exe_br_taken) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else if (raw_hazard) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_id = 1'b1;
        end
    end

    // Tag entering EXE: the issuing instruction, or a bubble.
    always_comb begin
        exe_d = '0;
        if (issue) begin
            exe_d.valid   = 1'b1;
            exe_d.rd      = SHADOW_RD_WIDTH'(id_rd_addr);
            exe_d.we      = id_rd_we;
            exe_d.is_load = id_is_load;
        end
    end

    // Forward selects for the issuing instruction; EXE-stage producer has priority.
    always_comb begin
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
        if (issue && id_rs1_used) begin
            if (shadow_hit(pipe_q[STG_EXE], SHADOW_RD_WIDTH'(id_rs1_addr)) && !pipe_q[STG_EXE].is_load) begin
                fwd_a_d = FWD_MEM;
            end else if (shadow_hit(pipe_q[STG_MEM], SHADOW_RD_WIDTH'(id_rs1_addr))) begin
                fwd_a_d = FWD_WB;
            end
        end
        if (issue && id_rs2_used) begin
            if (shadow_hit(pipe_q[STG_EXE], SHADOW_RD_WIDTH'(id_rs2_addr)) && !pipe_q[STG_EXE].is_load) begin
                fwd_b_d = FWD_MEM;
            end else if (shadow_hit(pipe_q[STG_MEM], SHADOW_RD_WIDTH'(id_rs2_addr))) begin
                fwd_b_d = FWD_WB;
            end
        end
    end

    // Shadow pipeline and forward-select registers; both freeze under ext_stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SHADOW_DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
        end else if (advance) begin
            pipe_q[STG_EXE] <= exe_d;
            pipe_q[STG_MEM] <= pipe_q[STG_EXE];
            pipe_q[STG_WB]  <= pipe_q[STG_MEM];
            fwd_a_q         <= fwd_a_d;
            fwd_b_q         <= fwd_b_d;
        end
    end

    assign forward_a_sel = fwd_a_q;
    assign forward_b_sel = fwd_b_q;

`ifdef HAZARD_PERF_EN
    logic [15:0] perf_stall_q, perf_flush_q;
    logic        raw_stall_cyc, br_flush_cyc;

    assign raw_stall_cyc = !ext_stall && !exe_br_taken && raw_hazard;
    assign br_flush_cyc  = !ext_stall && exe_br_taken;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (raw_stall_cyc && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
            if (br_flush_cyc && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + 16'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (LOAD_LAT=1 and LOAD_LAT=3) share
// the stimulus; each is compared to an issue-history reference model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic       id_rd_we = 1'b0, id_is_load = 1'b0;
    logic       exe_br_taken = 1'b0, ext_stall = 1'b0;

    logic       si1, sd1, fi1, fd1, si3, sd3, fi3, fd3;
    logic [1:0] fa1, fb1, fa3, fb3;
`ifdef HAZARD_PERF_EN
    logic [15:0] ps1, pf1, ps3, pf3;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_WIDTH(5), .NUM_REGS(32), .LOAD_LAT(1), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .exe_br_taken(exe_br_taken), .ext_stall(ext_stall),
        .stall_if(si1), .stall_id(sd1), .flush_if(fi1), .flush_id(fd1),
        .forward_a_sel(fa1), .forward_b_sel(fb1)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(ps1), .perf_flush_cnt(pf1)
`endif
    );

    hazard_scoreboard #(.REG_ADDR_WIDTH(5), .NUM_REGS(32), .LOAD_LAT(3), .CNT_WIDTH(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .exe_br_taken(exe_br_taken), .ext_stall(ext_stall),
        .stall_if(si3), .stall_id(sd3), .flush_if(fi3), .flush_id(fd3),
        .forward_a_sel(fa3), .forward_b_sel(fb3)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(ps3), .perf_flush_cnt(pf3)
`endif
    );

    // Observed outputs per instance: {stall_if, stall_id, flush_if, flush_id}.
    logic [3:0] obs_ctl [2];
    logic [1:0] obs_fa  [2];
    logic [1:0] obs_fb  [2];
    assign obs_ctl[0] = {si1, sd1, fi1, fd1};
    assign obs_ctl[1] = {si3, sd3, fi3, fd3};
    assign obs_fa[0]  = fa1;
    assign obs_fa[1]  = fa3;
    assign obs_fb[0]  = fb1;
    assign obs_fb[1]  = fb3;

    // Reference model: count of non-frozen cycles, the cycle at which each
    // register's load result becomes consumable, and the recent issue history.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } ent_t;

    int unsigned lat      [2] = '{1, 3};
    int unsigned t_act    [2];
    int unsigned ready_at [2][32];
    ent_t        hist     [2][3];   // [0] in EXE, [1] in MEM, [2] in WB
    logic [1:0]  exp_fa   [2];
    logic [1:0]  exp_fb   [2];
    int unsigned perf_st  [2];
    int unsigned perf_fl  [2];
    logic [3:0]  last_ctl [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_fwd(input int d, input int src, input bit used);
        if (!used || src == 0) return FWD_REG;
        if (hist[d][0].v && hist[d][0].we && !hist[d][0].ld && int'(hist[d][0].rd) == src) return FWD_MEM;
        if (hist[d][1].v && hist[d][1].we && int'(hist[d][1].rd) == src) return FWD_WB;
        return FWD_REG;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            t_act[d]   = 0;
            exp_fa[d]  = FWD_REG;
            exp_fb[d]  = FWD_REG;
            perf_st[d] = 0;
            perf_fl[d] = 0;
            for (int r = 0; r < 32; r++) ready_at[d][r] = 0;
            for (int s = 0; s < 3; s++) hist[d][s] = '0;
        end
    endtask

    // One clock cycle: drive ID inputs, check at the falling edge, advance model.
    task automatic step(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                        input int rd, input bit we, input bit ld, input bit br, input bit es);
        bit         haz, iss;
        logic [3:0] exp_ctl;
        ent_t       e;
        id_valid     = v;
        id_rs1_addr  = 5'(r1);
        id_rs1_used  = u1;
        id_rs2_addr  = 5'(r2);
        id_rs2_used  = u2;
        id_rd_addr   = 5'(rd);
        id_rd_we     = we;
        id_is_load   = ld;
        exe_br_taken = br;
        ext_stall    = es;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            haz = v && ((u1 && r1 != 0 && t_act[d] < ready_at[d][r1]) ||
                        (u2 && r2 != 0 && t_act[d] < ready_at[d][r2]));
            if (es)       exp_ctl = 4'b1100;
            else if (br)  exp_ctl = 4'b0011;
            else if (haz) exp_ctl = 4'b1101;
            else          exp_ctl = 4'b0000;
            chk(d == 0 ? "ctl_lat1" : "ctl_lat3", 8'(obs_ctl[d]), 8'(exp_ctl));
            chk(d == 0 ? "fwd_a_lat1" : "fwd_a_lat3", 8'(obs_fa[d]), 8'(exp_fa[d]));
            chk(d == 0 ? "fwd_b_lat1" : "fwd_b_lat3", 8'(obs_fb[d]), 8'(exp_fb[d]));
            last_ctl[d] = obs_ctl[d];
            if (!es) begin
                iss = v && !br && !haz;
                e = '0;
                if (iss) begin
                    e.v = 1'b1; e.rd = 5'(rd); e.we = we; e.ld = ld;
                end
                exp_fa[d] = iss ? model_fwd(d, r1, u1) : FWD_REG;
                exp_fb[d] = iss ? model_fwd(d, r2, u2) : FWD_REG;
                if (iss && ld && we && rd != 0) ready_at[d][rd] = t_act[d] + 1 + lat[d];
                hist[d][2] = hist[d][1];
                hist[d][1] = hist[d][0];
                hist[d][0] = e;
                t_act[d]++;
                if (!br && haz && perf_st[d] < 65535) perf_st[d]++;
                if (br && perf_fl[d] < 65535) perf_fl[d]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop();             step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic alu(input int rd, input int a, input int b); step(1, a, 1, b, 1, rd, 1, 0, 0, 0); endtask
    task automatic lw(input int rd, input int a);               step(1, a, 1, 0, 0, rd, 1, 1, 0, 0); endtask

    // Asynchronous reset pulse between clock edges, checked while asserted.
    task automatic do_reset();
        rst_n        = 1'b0;
        id_valid     = 1'b0;
        id_rs1_used  = 1'b0;
        id_rs2_used  = 1'b0;
        exe_br_taken = 1'b0;
        ext_stall    = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ctl", 8'(obs_ctl[d]), 8'h0);
            chk("rst_fwd_a", 8'(obs_fa[d]), 8'(FWD_REG));
            chk("rst_fwd_b", 8'(obs_fb[d]), 8'(FWD_REG));
        end
        model_reset();
        #1;
        rst_n = 1'b1;
        nop();
    endtask

    int n_st [2];

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // ALU back-to-back: EXE match on rs1.
        alu(1, 2, 2);
        alu(3, 1, 2);
        chk("t1_fa_lat1", 8'(fa1), 8'(FWD_MEM));
        chk("t1_fa_lat3", 8'(fa3), 8'(FWD_MEM));
        chk("t1_fb_lat1", 8'(fb1), 8'(FWD_REG));

        // ALU two apart: MEM match on rs2.
        alu(1, 2, 2);
        alu(7, 5, 6);
        alu(4, 2, 1);
        chk("t2_fb_lat1", 8'(fb1), 8'(FWD_WB));
        chk("t2_fb_lat3", 8'(fb3), 8'(FWD_WB));

        // Load-use: lw x5 then add x6,x5,x5 held in ID for 4 cycles.
        nop();
        lw(5, 2);
        n_st = '{0, 0};
        for (int i = 0; i < 4; i++) begin
            alu(6, 5, 5);
            for (int d = 0; d < 2; d++) if (last_ctl[d][2]) n_st[d]++;
            if (i == 1) begin
                chk("t3_fa_lat1", 8'(fa1), 8'(FWD_WB));
                chk("t3_fb_lat1", 8'(fb1), 8'(FWD_WB));
            end
            if (i == 3) begin
                chk("t3_fa_lat3", 8'(fa3), 8'(FWD_REG));
                chk("t3_fb_lat3", 8'(fb3), 8'(FWD_REG));
            end
        end
        chk("t3_stalls_lat1", 8'(n_st[0]), 8'd1);
        chk("t3_stalls_lat3", 8'(n_st[1]), 8'd3);

        // Branch flush beats a load-use stall; the flushed load must not set x9.
        lw(7, 2);
        step(1, 7, 1, 0, 0, 9, 1, 1, 1, 0);
        chk("t4_flush_lat1", 8'(last_ctl[0]), 8'b0011);
        chk("t4_flush_lat3", 8'(last_ctl[1]), 8'b0011);
        alu(10, 9, 9);
        chk("t4_x9_lat1", 8'(last_ctl[0]), 8'h0);
        chk("t4_x9_lat3", 8'(last_ctl[1]), 8'h0);

        // External stall freezes a pending load-use countdown.
        nop(); nop(); nop();
        lw(10, 2);
        alu(11, 10, 10);
        for (int i = 0; i < 4; i++) step(1, 10, 1, 10, 1, 11, 1, 0, 0, 1);
        n_st = '{0, 0};
        for (int i = 0; i < 3; i++) begin
            alu(11, 10, 10);
            for (int d = 0; d < 2; d++) if (last_ctl[d][2]) n_st[d]++;
        end
        chk("t5_resume_lat1", 8'(n_st[0]), 8'd0);
        chk("t5_resume_lat3", 8'(n_st[1]), 8'd2);

        // Loads to x0 are never tracked.
        lw(0, 2);
        alu(12, 0, 0);
        chk("t6_x0_ctl_lat3", 8'(last_ctl[1]), 8'h0);
        chk("t6_x0_fa_lat1", 8'(fa1), 8'(FWD_REG));
        chk("t6_x0_fa_lat3", 8'(fa3), 8'(FWD_REG));

        // Reset with a load pending clears the scoreboard.
        lw(13, 2);
        do_reset();
        alu(14, 13, 13);
        chk("t7_rst_lat1", 8'(last_ctl[0]), 8'h0);
        chk("t7_rst_lat3", 8'(last_ctl[1]), 8'h0);

        // Randomised traffic on a small register window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(9) != 0,
                     int'($urandom_range(7)), $urandom_range(3) != 0,
                     int'($urandom_range(7)), $urandom_range(1) != 0,
                     int'($urandom_range(7)), $urandom_range(4) != 0,
                     $urandom_range(2) == 0,
                     $urandom_range(9) == 0,
                     $urandom_range(6) == 0);
            end
        end

`ifdef HAZARD_PERF_EN
        chk("perf_stall_lat1", 8'(ps1), 8'(perf_st[0]));
        chk("perf_flush_lat1", 8'(pf1), 8'(perf_fl[0]));
        chk("perf_stall_lat3", 8'(ps3), 8'(perf_st[1]));
        chk("perf_flush_lat3", 8'(pf3), 8'(perf_fl[1]));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
